// File: rtl/bc_skid_buf.sv
// bc_skid_buf: two-entry valid/ready skid buffer.
// Upstream ready comes from registered occupancy only, so the combinational
// ready path between pipeline stages is cut while one word per cycle flows.
module bc_skid_buf #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iVld,
  input  logic [WIDTH-1:0] iDat,
  output logic             oRdy,
  output logic             oVld,
  output logic [WIDTH-1:0] oDat,
  input  logic             iRdy,
  output logic [1:0]       oCnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  // Handshake outputs depend only on registered state (plus reset gating).
  always_comb begin
    oVld     = (state_q != EMPTY);
    oRdy     = (state_q != FULL) & ~rst;
    oDat     = out_q;
    oCnt     = state_q;
    in_fire  = iVld & oRdy;
    out_fire = oVld & iRdy;
  end

  // Next-state and data-path selection; everything holds by default.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          out_d   = iDat;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          out_d = iDat;
        end else if (in_fire) begin
          // Consumer stalled: the extra word lands in the skid slot.
          skid_d  = iDat;
          state_d = FULL;
        end else if (out_fire) begin
          // out_q deliberately keeps the last transferred word.
          state_d = EMPTY;
        end
      end
      FULL: begin
        // oRdy is low here, so only the output side can move.
        if (out_fire) begin
          out_d   = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and output register; reset discards contents and voids handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= INI_DATA;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Skid slot needs no reset: it is only read after being written in FULL.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_bc_skid_buf.sv
// Directed plus short randomized bench for bc_skid_buf.
module tb_bc_skid_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        iVld;
  logic [31:0] iDat;
  logic        oRdy;
  logic        oVld;
  logic [31:0] oDat;
  logic        iRdy;
  logic [1:0]  oCnt;

  int nchk  = 0;
  int nfail = 0;

  bc_skid_buf #(.WIDTH(32), .INI_DATA(32'h1)) dut (
    .clk (clk),
    .rst (rst),
    .iVld(iVld),
    .iDat(iDat),
    .oRdy(oRdy),
    .oVld(oVld),
    .oDat(oDat),
    .iRdy(iRdy),
    .oCnt(oCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs changed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];

  initial begin
    // Reset with iVld asserted.
    rst = 1'b1; iVld = 1'b1; iDat = 32'hdead_beef; iRdy = 1'b0;
    tick(); tick();
    chk("rst_vld", oVld, 0);
    chk("rst_rdy", oRdy, 0);
    chk("rst_cnt", oCnt, 0);
    chk("rst_dat", oDat, 32'h1);
    rst = 1'b0; iVld = 1'b0;
    #1;
    chk("rst_fall_rdy", oRdy, 1);

    // Streaming 1..10 with the consumer always ready.
    iRdy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      iVld = 1'b1; iDat = i;
      tick();
      chk("strm_dat", oDat, i);
      chk("strm_vld", oVld, 1);
      chk("strm_cnt", oCnt, 1);
      chk("strm_rdy", oRdy, 1);
    end
    iVld = 1'b0;
    tick();
    chk("strm_end_cnt", oCnt, 0);
    chk("strm_end_vld", oVld, 0);
    chk("strm_end_dat", oDat, 10);

    // Backpressure: A0 on output, A1 skids, A2 held off.
    iVld = 1'b1; iDat = 32'hA0;
    tick();
    chk("bp_a0_dat", oDat, 32'hA0);
    chk("bp_a0_cnt", oCnt, 1);
    iRdy = 1'b0; iDat = 32'hA1;
    tick();
    chk("bp_full_cnt", oCnt, 2);
    chk("bp_full_rdy", oRdy, 0);
    chk("bp_full_dat", oDat, 32'hA0);
    chk("bp_full_vld", oVld, 1);
    iDat = 32'hA2;
    tick();
    chk("bp_hold_cnt", oCnt, 2);
    chk("bp_hold_dat", oDat, 32'hA0);
    iRdy = 1'b1;
    tick();
    chk("bp_a1_dat", oDat, 32'hA1);
    chk("bp_a1_cnt", oCnt, 1);
    chk("bp_a1_rdy", oRdy, 1);
    tick();
    chk("bp_a2_dat", oDat, 32'hA2);
    chk("bp_a2_cnt", oCnt, 1);
    iVld = 1'b0;
    tick();
    chk("bp_empty_cnt", oCnt, 0);

    // Drain from FULL: oCnt 2,1,0 and oDat keeps the last word.
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'hB0;
    tick();
    iDat = 32'hB1;
    tick();
    chk("dr_cnt2", oCnt, 2);
    iVld = 1'b0; iRdy = 1'b1; iDat = 32'hFFFF_FFFF;
    tick();
    chk("dr_cnt1", oCnt, 1);
    chk("dr_dat1", oDat, 32'hB1);
    tick();
    chk("dr_cnt0", oCnt, 0);
    chk("dr_vld0", oVld, 0);
    chk("dr_dat0", oDat, 32'hB1);
    tick();
    chk("dr_hold_cnt", oCnt, 0);
    chk("dr_hold_dat", oDat, 32'hB1);

    // Mid-operation reset while FULL with 0x55, 0x66.
    iRdy = 1'b0; iVld = 1'b1; iDat = 32'h55;
    tick();
    iDat = 32'h66;
    tick();
    chk("mr_full_cnt", oCnt, 2);
    rst = 1'b1; iRdy = 1'b1; iVld = 1'b1; iDat = 32'h77;
    #1;
    chk("mr_rst_rdy", oRdy, 0);
    tick();
    chk("mr_vld", oVld, 0);
    chk("mr_cnt", oCnt, 0);
    chk("mr_dat", oDat, 32'h1);
    rst = 1'b0; iVld = 1'b0;
    tick();
    chk("mr_post_vld", oVld, 0);
    chk("mr_post_dat", oDat, 32'h1);
    chk("mr_post_rdy", oRdy, 1);

    // Randomized traffic against a scoreboard queue.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      bit inf, outf;
      chk("rnd_cnt", oCnt, q.size());
      chk("rnd_vld", oVld, (q.size() != 0));
      chk("rnd_rdy", oRdy, (q.size() != 2));
      if (q.size() != 0) chk("rnd_dat", oDat, q[0]);
      iVld = ($urandom_range(0, 3) != 0);
      iRdy = ($urandom_range(0, 2) != 0);
      iDat = $urandom;
      inf  = iVld && (q.size() < 2);
      outf = (q.size() != 0) && iRdy;
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(iDat);
      tick();
    end

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
